// File: rtl/arp_addr_gen.sv
// ---------------------------------------------------------------------------
// arp_addr_gen
// Arpeggiator and wavetable read-address generator for the sine-table BRAM.
// A root sample period is derived from the board switches. When arpeggio
// mode is on, the period steps through four note ratios at a fixed dwell
// rate. The BRAM read address advances once per sample period.
//
// Ports:
//   CLK100MHZ    in   system clock; all logic runs on its rising edge
//   rst          in   synchronous, active-high reset
//   sw[7:0]      in   base-pitch offset; root period = 2*(BASE_OFFSET+sw)
//   arp_btn      in   debounced button level; each rising edge toggles arp_on
//   addra        out  BRAM read address, incremented once per sample period
//   sample_tick  out  one-cycle pulse, high in the cycle addra takes its new value
//   note[1:0]    out  current arpeggio note index
//   arp_on       out  arpeggio mode enabled
//   period[10:0] out  currently selected sample period in clocks (combinational)
// ---------------------------------------------------------------------------
module arp_addr_gen #(
  parameter int unsigned BASE_OFFSET = 746,
  parameter int unsigned NOTE_TICKS  = 25_000_000,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic [7:0]        sw,
  input  logic              arp_btn,
  output logic [ADDR_W-1:0] addra,
  output logic              sample_tick,
  output logic [1:0]        note,
  output logic              arp_on,
  output logic [10:0]       period
);

  localparam int unsigned PER_W   = 11;
  localparam int unsigned DWELL_W = 27;

  localparam logic [PER_W-1:0]   BASE_P     = PER_W'(BASE_OFFSET);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(NOTE_TICKS - 1);

  typedef enum logic [1:0] {
    NOTE0 = 2'd0,
    NOTE1 = 2'd1,
    NOTE2 = 2'd2,
    NOTE3 = 2'd3
  } note_e;

  // Registers
  logic [PER_W-1:0]   cnt_q,   cnt_d;
  logic [ADDR_W-1:0]  addra_q, addra_d;
  logic               tick_q,  tick_d;
  logic               btn_q;
  logic               arp_on_q;
  logic [DWELL_W-1:0] dwell_q;
  note_e              note_q;

  // Combinational helpers
  logic [PER_W-1:0] d0_c;
  logic [PER_W-1:0] period_c;
  logic [PER_W-1:0] last_c;
  logic             rise_c;

  // Root period and per-note period; all shifts truncate.
  always_comb begin
    d0_c     = (BASE_P + {3'd0, sw}) << 1;
    period_c = d0_c;
    case (note_q)
      NOTE0:   period_c = d0_c;
      NOTE1:   period_c = d0_c - (d0_c >> 2);
      NOTE2:   period_c = (d0_c >> 1) + (d0_c >> 3);
      NOTE3:   period_c = d0_c >> 1;
      default: period_c = d0_c;
    endcase
    last_c = period_c - PER_W'(1);
  end

  // Sample divider: >= so that a period shrinking below cnt wraps at once.
  always_comb begin
    cnt_d   = cnt_q + PER_W'(1);
    addra_d = addra_q;
    tick_d  = 1'b0;
    if (cnt_q >= last_c) begin
      cnt_d   = '0;
      addra_d = addra_q + ADDR_W'(1);
      tick_d  = 1'b1;
    end
  end

  assign rise_c = arp_btn & ~btn_q;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      cnt_q   <= '0;
      addra_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addra_q <= addra_d;
      tick_q  <= tick_d;
    end
  end

  // Arpeggio FSM: toggle edge beats dwell expiry; arp off pins note to NOTE0.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      btn_q    <= 1'b0;
      arp_on_q <= 1'b0;
      dwell_q  <= '0;
      note_q   <= NOTE0;
    end else begin
      btn_q <= arp_btn;
      if (rise_c) begin
        arp_on_q <= ~arp_on_q;
        dwell_q  <= '0;
        note_q   <= NOTE0;
      end else if (arp_on_q) begin
        if (dwell_q == DWELL_LAST) begin
          dwell_q <= '0;
          case (note_q)
            NOTE0:   note_q <= NOTE1;
            NOTE1:   note_q <= NOTE2;
            NOTE2:   note_q <= NOTE3;
            NOTE3:   note_q <= NOTE0;
            default: note_q <= NOTE0;
          endcase
        end else begin
          dwell_q <= dwell_q + DWELL_W'(1);
        end
      end else begin
        dwell_q <= '0;
        note_q  <= NOTE0;
      end
    end
  end

  assign addra       = addra_q;
  assign sample_tick = tick_q;
  assign note        = note_q;
  assign arp_on      = arp_on_q;
  assign period      = period_c;

endmodule

// File: tb/tb_arp_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_arp_addr_gen
// Self-checking bench for arp_addr_gen: directed scenarios plus randomized
// switch/button/reset activity compared every cycle against a behavioural
// model. A second, narrow-address instance exposes address wrap quickly.
// ---------------------------------------------------------------------------
module tb_arp_addr_gen;

  localparam int NT = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       arp_btn;

  logic [7:0]  addra;
  logic        sample_tick;
  logic [1:0]  note;
  logic        arp_on;
  logic [10:0] period;

  logic [2:0]  addra_w;
  logic        tick_w;
  logic [1:0]  note_w;
  logic        arp_w;
  logic [10:0] period_w;

  always #5 clk = ~clk;

  arp_addr_gen #(.BASE_OFFSET(746), .NOTE_TICKS(NT), .ADDR_W(8)) dut (
    .CLK100MHZ(clk), .rst(rst), .sw(sw), .arp_btn(arp_btn),
    .addra(addra), .sample_tick(sample_tick), .note(note),
    .arp_on(arp_on), .period(period)
  );

  arp_addr_gen #(.BASE_OFFSET(746), .NOTE_TICKS(NT), .ADDR_W(3)) dut_w (
    .CLK100MHZ(clk), .rst(rst), .sw(sw), .arp_btn(arp_btn),
    .addra(addra_w), .sample_tick(tick_w), .note(note_w),
    .arp_on(arp_w), .period(period_w)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: elapsed-cycle bookkeeping rather than counters-per-register.
  int m_since;      // cycles since the last tick (or reset)
  int m_addr;       // ticks since reset, mod 256
  bit m_tick;
  bit m_arp;
  int m_arp_cyc;    // cycles elapsed since the last toggle edge
  bit m_prev;

  function automatic int ref_period(input int s, input int n);
    int d0;
    d0 = 2 * (746 + s);
    case (n)
      0:       return d0;
      1:       return d0 - d0 / 4;
      2:       return d0 / 2 + d0 / 8;
      default: return d0 / 2;
    endcase
  endfunction

  function automatic int m_note();
    return m_arp ? (m_arp_cyc / NT) % 4 : 0;
  endfunction

  task automatic model_edge();
    int p;
    if (rst) begin
      m_since = 0; m_addr = 0; m_tick = 0;
      m_arp = 0; m_arp_cyc = 0; m_prev = 0;
    end else begin
      p = ref_period(int'(sw), m_note());
      if (m_since >= p - 1) begin
        m_since = 0;
        m_addr  = (m_addr + 1) % 256;
        m_tick  = 1;
      end else begin
        m_since++;
        m_tick = 0;
      end
      if (arp_btn && !m_prev) begin
        m_arp     = !m_arp;
        m_arp_cyc = 0;
      end else if (m_arp) begin
        m_arp_cyc++;
      end
      m_prev = arp_btn;
    end
  endtask

  task automatic compare_all();
    check("addra",   32'(addra),       32'(m_addr));
    check("tick",    32'(sample_tick), 32'(m_tick));
    check("note",    32'(note),        32'(m_note()));
    check("arp_on",  32'(arp_on),      32'(m_arp));
    check("period",  32'(period),      32'(ref_period(int'(sw), m_note())));
    check("addra_w", 32'(addra_w),     32'(m_addr % 8));
    check("tick_w",  32'(tick_w),      32'(m_tick));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (sample_tick !== 1'b1 && n < 10000);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addra"},  32'(addra),       32'd0);
    check({tag, "_tick"},   32'(sample_tick), 32'd0);
    check({tag, "_note"},   32'(note),        32'd0);
    check({tag, "_arp"},    32'(arp_on),      32'd0);
    check({tag, "_period"}, 32'(period),      32'(ref_period(int'(sw), 0)));
  endtask

  int gap;
  int exp_p [4] = '{1492, 1119, 932, 746};
  int budget;

  initial begin
    rst = 1'b1; sw = 8'd0; arp_btn = 1'b0;
    m_since = 0; m_addr = 0; m_tick = 0; m_arp = 0; m_arp_cyc = 0; m_prev = 0;

    // Reset, sw=0, arp off
    step(2);
    check_reset_vals("rst");
    check("rst_period_abs", 32'(period), 32'd1492);
    rst = 1'b0;
    wait_tick(gap);
    check("first_tick_gap", 32'(gap), 32'd1492);
    check("first_tick_addra", 32'(addra), 32'd1);
    for (int i = 0; i < 2; i++) begin
      wait_tick(gap);
      check("sw0_gap", 32'(gap), 32'd1492);
      check("sw0_note", 32'(note), 32'd0);
    end

    // sw=255
    sw = 8'd255;
    wait_tick(gap);
    for (int i = 0; i < 2; i++) begin
      wait_tick(gap);
      check("sw255_gap", 32'(gap), 32'd2002);
    end
    check("sw255_period", 32'(period), 32'd2002);

    // Arpeggio stepping with sw=0
    sw = 8'd0;
    arp_btn = 1'b1;
    step(1);
    check("arp_on_next", 32'(arp_on), 32'd1);
    arp_btn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("arp_note", 32'(note), 32'(k));
      check("arp_period", 32'(period), 32'(exp_p[k]));
      step(NT - 1);
      check("arp_note_pre", 32'(note), 32'(k));
      step(1);
    end
    check("arp_note_wrap", 32'(note), 32'd0);
    step(3 * NT);
    check("arp_note3", 32'(note), 32'd3);

    // Second edge while on note 3
    arp_btn = 1'b1;
    step(1);
    check("off_arp", 32'(arp_on), 32'd0);
    check("off_note", 32'(note), 32'd0);
    check("off_period", 32'(period), 32'd1492);
    arp_btn = 1'b0;
    step(600);
    check("off_hold_note", 32'(note), 32'd0);

    // Toggle edge in the exact dwell-expiry cycle; then a long held button
    arp_btn = 1'b1;
    step(1);
    arp_btn = 1'b0;
    step(NT - 1);
    arp_btn = 1'b1;
    step(1);
    check("coinc_arp", 32'(arp_on), 32'd0);
    check("coinc_note", 32'(note), 32'd0);
    step(300);
    check("held_arp", 32'(arp_on), 32'd0);
    arp_btn = 1'b0;
    step(1);
    arp_btn = 1'b1;
    step(1);
    check("reon_arp", 32'(arp_on), 32'd1);
    step(300);
    check("reon_held_arp", 32'(arp_on), 32'd1);
    arp_btn = 1'b0;

    // Randomized activity
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(499, 0) == 0) sw = 8'($urandom_range(255, 0));
      if ($urandom_range(49, 0) == 0)  arp_btn = ~arp_btn;
      rst = ($urandom_range(2999, 0) == 0);
      step(1);
    end
    rst = 1'b0;

    // Mid-sequence reset at note=2, addra=37
    rst = 1'b1; sw = 8'd0; arp_btn = 1'b0;
    step(1);
    rst = 1'b0;
    arp_btn = 1'b1;
    step(1);
    arp_btn = 1'b0;
    budget = 0;
    while (!(m_addr == 37 && m_note() == 2) && budget < 60000) begin
      step(1);
      budget++;
    end
    check("reach_37_note2", 32'(budget < 60000), 32'd1);
    check("pre_rst_addra", 32'(addra), 32'd37);
    check("pre_rst_note", 32'(note), 32'd2);
    rst = 1'b1;
    step(1);
    check_reset_vals("midrst");
    rst = 1'b0;
    wait_tick(gap);
    check("midrst_gap", 32'(gap), 32'd1492);
    check("midrst_addra", 32'(addra), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
